// File: rtl/alu_operand_sequencer_if.sv
// Operand/result bundle between the sequencer (master) and the combinational ALU (slave).
// No latency or backpressure here; operands_valid qualifies a/b/operation.
interface alu_operand_sequencer_if #(
  parameter int N = 4
);
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [3:0]   operation;
  logic         operands_valid;
  logic [N-1:0] y_in;
  logic [3:0]   flags_in;
  logic [N-1:0] result_q;
  logic [3:0]   flags_q;

  modport master (
    output a, b, operation, operands_valid, result_q, flags_q,
    input  y_in, flags_in
  );

  modport slave (
    input  a, b, operation, operands_valid, result_q, flags_q,
    output y_in, flags_in
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Collects A, B, opcode via debounced button presses, drives them to the ALU, snapshots result/flags.
// Press-to-commit latency: 2 sync + DEBOUNCE_CYCLES + 1 cycles; no backpressure, user pace only.
module alu_operand_sequencer_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n,
  output logic press
);
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        cnt   <= '0;
        // Pulse only on the accepted 1->0 transition; releases are silent.
        press <= level & ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module alu_operand_sequencer #(
  parameter int N               = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [N-1:0]                     sw,
  input  logic                             btn_enter_n,
  input  logic                             btn_clear_n,
  alu_operand_sequencer_if.master          alu,
  output logic                             op_invalid,
  output logic [2:0]                       stage
);
  typedef enum logic [2:0] {
    LOAD_A  = 3'b000,
    LOAD_B  = 3'b001,
    LOAD_OP = 3'b010,
    EXEC    = 3'b011,
    SHOW    = 3'b100
  } state_t;

  localparam logic [3:0] OP_CLEAR = 4'b1111;

  state_t state;
  logic   enter_pulse;
  logic   clear_pulse;
  logic   op_supported;

  alu_operand_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enter (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_enter_n),
    .press (enter_pulse)
  );

  alu_operand_sequencer_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_n (btn_clear_n),
    .press (clear_pulse)
  );

  // Codes 1010..1110 have no ALU function; 1111 is the ALU's own clear code.
  assign op_supported = (sw[3:0] <= 4'd9) || (sw[3:0] == OP_CLEAR);
  assign stage        = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= LOAD_A;
      alu.a              <= '0;
      alu.b              <= '0;
      alu.operation      <= OP_CLEAR;
      alu.operands_valid <= 1'b0;
      alu.result_q       <= '0;
      alu.flags_q        <= '0;
      op_invalid         <= 1'b0;
    end else if (clear_pulse) begin
      state              <= LOAD_A;
      alu.a              <= '0;
      alu.b              <= '0;
      alu.operation      <= OP_CLEAR;
      alu.operands_valid <= 1'b0;
      alu.result_q       <= '0;
      alu.flags_q        <= '0;
      op_invalid         <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          if (enter_pulse) begin
            alu.a <= sw;
            state <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (enter_pulse) begin
            alu.b <= sw;
            state <= LOAD_OP;
          end
        end
        LOAD_OP: begin
          if (enter_pulse) begin
            alu.operation      <= op_supported ? sw[3:0] : OP_CLEAR;
            op_invalid         <= ~op_supported;
            alu.operands_valid <= 1'b1;
            state              <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable for this whole cycle, so the ALU has settled.
          alu.result_q <= alu.y_in;
          alu.flags_q  <= alu.flags_in;
          state        <= SHOW;
        end
        SHOW: begin
          if (enter_pulse) begin
            alu.operands_valid <= 1'b0;
            state              <= LOAD_A;
          end
        end
        default: begin
          alu.operands_valid <= 1'b0;
          state              <= LOAD_A;
        end
      endcase
    end
  end
endmodule
